// File: rtl/regfile_dump_reader_pkg.sv
// rtl/regfile_dump_reader_pkg.sv - shared encodings and helpers for the register dump reader
package regfile_dump_reader_pkg;

    localparam int REG_BYTES = 4;
    localparam int REG_IDX_W = 5;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_SEND_IDX  = 3'd2;
    localparam logic [2:0] ST_SEND_DATA = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    // Big-endian byte select: index 0 is the most significant byte.
    function automatic logic [7:0] word_byte_be(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_serializer.sv
// rtl/regfile_dump_reader_serializer.sv - holds one snapshotted word and steps through its bytes
module word_byte_serializer
    import regfile_dump_reader_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_load,
    input  logic [REG_BYTES*8-1:0]   i_word,
    input  logic                     i_advance,
    output logic [7:0]               o_byte,
    output logic                     o_last_byte
);

    logic [REG_BYTES*8-1:0] r_shadow;
    logic [1:0]             r_byte_cnt;

    // Capture the word on load; step the byte pointer on each accepted data byte.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shadow   <= '0;
            r_byte_cnt <= 2'd0;
        end else if (i_load) begin
            r_shadow   <= i_word;
            r_byte_cnt <= 2'd0;
        end else if (i_advance) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end

    assign o_byte      = word_byte_be(r_shadow, r_byte_cnt);
    assign o_last_byte = (r_byte_cnt == 2'(REG_BYTES - 1));

endmodule

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks the register file read port and streams each word as bytes
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = 31,
    parameter int EMIT_INDEX = 1
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [REG_IDX_W-1:0]  rd_addr,
    input  logic [31:0]           rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [REG_IDX_W-1:0] LP_FIRST = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] LP_LAST  = REG_IDX_W'(LAST_REG);
    localparam logic                 LP_EMIT  = (EMIT_INDEX != 0);

    logic [2:0]           r_state;
    logic [REG_IDX_W-1:0] r_rd_addr;
    logic                 r_out_valid;
    logic                 r_busy;

    logic       w_handshake;
    logic       w_load;
    logic       w_advance;
    logic [7:0] w_ser_byte;
    logic       w_last_byte;

    assign w_handshake = r_out_valid && out_ready;
    assign w_load      = (r_state == ST_LOAD) && !abort;
    assign w_advance   = (r_state == ST_SEND_DATA) && w_handshake && !abort;

    word_byte_serializer u_ser (
        .clk         (CLK),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_word      (rd_data),
        .i_advance   (w_advance),
        .o_byte      (w_ser_byte),
        .o_last_byte (w_last_byte)
    );

    // Dump sequencer: address walk, stream valid and busy tracking; abort overrides everything.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (abort && (r_state != ST_IDLE)) begin
            r_state     <= ST_IDLE;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_rd_addr <= LP_FIRST;
                        r_busy    <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_out_valid <= 1'b1;
                    r_state     <= LP_EMIT ? ST_SEND_IDX : ST_SEND_DATA;
                end
                ST_SEND_IDX: begin
                    if (w_handshake) begin
                        r_state <= ST_SEND_DATA;
                    end
                end
                ST_SEND_DATA: begin
                    if (w_handshake && w_last_byte) begin
                        r_out_valid <= 1'b0;
                        if (r_rd_addr == LP_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                            r_state   <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy    <= 1'b0;
                    r_rd_addr <= '0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stream byte is a pure function of state and snapshot, never of out_ready.
    always_comb begin
        out_data = 8'd0;
        case (r_state)
            ST_SEND_IDX:  out_data = {{(8 - REG_IDX_W){1'b0}}, r_rd_addr};
            ST_SEND_DATA: out_data = w_ser_byte;
            default:      out_data = 8'd0;
        endcase
    end

    assign rd_addr   = r_rd_addr;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start_a, abort_a, ready_a;
    logic        start_b, abort_b, ready_b;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic        valid_a, valid_b;
    logic [7:0]  byte_a, byte_b;
    logic        busy_a, busy_b, done_a, done_b;

    logic [31:0] regs [32];
    assign data_a = (addr_a == 5'd0) ? 32'd0 : regs[addr_a];
    assign data_b = (addr_b == 5'd0) ? 32'd0 : regs[addr_b];

    regfile_dump_reader dut_a (
        .CLK(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
        .rd_addr(addr_a), .rd_data(data_a), .out_valid(valid_a), .out_ready(ready_a),
        .out_data(byte_a), .busy(busy_a), .done(done_a)
    );

    regfile_dump_reader #(.FIRST_REG(31), .LAST_REG(31), .EMIT_INDEX(0)) dut_b (
        .CLK(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
        .rd_addr(addr_b), .rd_data(data_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_data(byte_b), .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic [7:0] obs_a[$];
    logic [7:0] obs_b[$];
    logic [7:0] exp_q[$];
    int done_cnt_a = 0, done_cyc_a = 0, done_cnt_b = 0, done_cyc_b = 0;
    int fv_cyc = -1;
    int hold_viol = 0;
    logic pstall = 1'b0;
    logic [7:0] pbyte = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record accepted bytes, done pulses and any change of a stalled byte.
    always @(negedge clk) begin
        if (valid_a && ready_a && !abort_a && reset_n) obs_a.push_back(byte_a);
        if (valid_b && ready_b && !abort_b && reset_n) obs_b.push_back(byte_b);
        if (done_a) begin done_cnt_a <= done_cnt_a + 1; done_cyc_a <= cyc; end
        if (done_b) begin done_cnt_b <= done_cnt_b + 1; done_cyc_b <= cyc; end
        if (valid_a && fv_cyc < 0) fv_cyc <= cyc;
        if (pstall && !(valid_a && byte_a == pbyte)) hold_viol <= hold_viol + 1;
        pstall <= valid_a && !ready_a && !abort_a && reset_n;
        pbyte  <= byte_a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference stream: index byte (optional) then the word big-endian, for each register in range.
    function automatic void build_exp(input int first, input int last, input bit emit);
        exp_q.delete();
        for (int r = first; r <= last; r++) begin
            logic [31:0] v;
            v = (r == 0) ? 32'd0 : regs[r];
            if (emit) exp_q.push_back(8'(r));
            for (int b = 3; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
        end
    endfunction

    function automatic void randomize_regs();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        checks++; if (valid_a !== 1'b0) $display("FAIL reset_valid got=%b want=0", valid_a); else passed++;
        checks++; if (byte_a !== 8'h00) $display("FAIL reset_data got=%h want=00", byte_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy_a); else passed++;
        checks++; if (done_a !== 1'b0) $display("FAIL reset_done got=%b want=0", done_a); else passed++;
        checks++; if (addr_a !== 5'd0) $display("FAIL reset_addr got=%0d want=0", addr_a); else passed++;
        checks++; if (valid_b !== 1'b0 || busy_b !== 1'b0) $display("FAIL reset_b got=%b%b want=00", valid_b, busy_b); else passed++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_full_dump();
        int s, n, dc0;
        logic [7:0] pre [15];
        pre = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h05};
        randomize_regs();
        regs[1] = 32'hDEADBEEF;
        regs[2] = 32'h00000005;
        build_exp(0, 31, 1);
        obs_a.delete();
        ready_a = 1'b1;
        dc0 = done_cnt_a;
        fv_cyc = -1;
        s = cyc;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (done_cnt_a == dc0 && n < 400) begin tick(); n++; end
        tick(); tick(); tick();
        checks++; if (done_cnt_a == dc0) $display("FAIL full_timeout got=no_done want=done"); else passed++;
        checks++; if (obs_a.size() != 160) $display("FAIL full_len got=%0d want=160", obs_a.size()); else passed++;
        checks++; if (fv_cyc - s != 2) $display("FAIL full_first_valid got=%0d want=2", fv_cyc - s); else passed++;
        checks++; if (done_cyc_a - s != 193) $display("FAIL full_done_cycle got=%0d want=193", done_cyc_a - s); else passed++;
        checks++; if (done_cnt_a - dc0 != 1) $display("FAIL full_done_count got=%0d want=1", done_cnt_a - dc0); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL full_busy_end got=%b want=0", busy_a); else passed++;
        for (int i = 0; i < 15 && i < obs_a.size(); i++) begin
            checks++; if (obs_a[i] !== pre[i]) $display("FAIL full_prefix[%0d] got=%h want=%h", i, obs_a[i], pre[i]); else passed++;
        end
        for (int i = 0; i < obs_a.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_a[i] !== exp_q[i]) $display("FAIL full_stream[%0d] got=%h want=%h", i, obs_a[i], exp_q[i]); else passed++;
        end
    endtask

    task automatic test_backpressure();
        int n, dc0, stall_left, hv0;
        bit stalled;
        randomize_regs();
        build_exp(0, 31, 1);
        obs_a.delete();
        dc0 = done_cnt_a;
        hv0 = hold_viol;
        stalled = 1'b0;
        stall_left = 0;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (done_cnt_a == dc0 && n < 3000) begin
            if (!stalled && obs_a.size() == 22) begin stalled = 1'b1; stall_left = 7; end
            if (stall_left > 0) begin ready_a = 1'b0; stall_left--; end
            else ready_a = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        ready_a = 1'b1;
        tick(); tick();
        checks++; if (done_cnt_a == dc0) $display("FAIL bp_timeout got=no_done want=done"); else passed++;
        checks++; if (!stalled) $display("FAIL bp_stall_reached got=0 want=1"); else passed++;
        checks++; if (hold_viol != hv0) $display("FAIL bp_hold got=%0d want=0 changes", hold_viol - hv0); else passed++;
        checks++; if (obs_a.size() != exp_q.size()) $display("FAIL bp_len got=%0d want=%0d", obs_a.size(), exp_q.size()); else passed++;
        for (int i = 0; i < obs_a.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_a[i] !== exp_q[i]) $display("FAIL bp_stream[%0d] got=%h want=%h", i, obs_a[i], exp_q[i]); else passed++;
        end
    endtask

    task automatic test_snapshot();
        int n, dc0;
        bit written;
        randomize_regs();
        regs[3] = 32'h0;
        build_exp(0, 31, 1);
        obs_a.delete();
        dc0 = done_cnt_a;
        written = 1'b0;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (done_cnt_a == dc0 && n < 400) begin
            if (!written && obs_a.size() >= 16) begin regs[3] = 32'h11223344; written = 1'b1; end
            tick();
            n++;
        end
        tick(); tick();
        checks++; if (!written || obs_a.size() != 160) $display("FAIL snap_len got=%0d want=160", obs_a.size()); else passed++;
        for (int i = 16; i < 20 && i < obs_a.size(); i++) begin
            checks++; if (obs_a[i] !== 8'h00) $display("FAIL snap_x3[%0d] got=%h want=00", i - 16, obs_a[i]); else passed++;
        end
        for (int i = 0; i < obs_a.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_a[i] !== exp_q[i]) $display("FAIL snap_stream[%0d] got=%h want=%h", i, obs_a[i], exp_q[i]); else passed++;
        end
    endtask

    task automatic test_abort();
        int n, dc0;
        randomize_regs();
        build_exp(0, 31, 1);
        obs_a.delete();
        dc0 = done_cnt_a;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (obs_a.size() < 53 && n < 400) begin tick(); n++; end
        checks++; if (valid_a !== 1'b1 || byte_a !== exp_q[53]) $display("FAIL abort_pre got=%b/%h want=1/%h", valid_a, byte_a, exp_q[53]); else passed++;
        ready_a = 1'b0;
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        checks++; if (valid_a !== 1'b0) $display("FAIL abort_valid got=%b want=0", valid_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy_a); else passed++;
        checks++; if (addr_a !== 5'd0) $display("FAIL abort_addr got=%0d want=0", addr_a); else passed++;
        ready_a = 1'b1;
        repeat (20) tick();
        checks++; if (done_cnt_a != dc0) $display("FAIL abort_no_done got=%0d want=0 pulses", done_cnt_a - dc0); else passed++;
        checks++; if (obs_a.size() != 53) $display("FAIL abort_no_bytes got=%0d want=53", obs_a.size()); else passed++;
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        tick();
        checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0) $display("FAIL abort_vs_start got=%b%b want=00", busy_a, valid_a); else passed++;
        obs_a.delete();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (done_cnt_a == dc0 && n < 400) begin tick(); n++; end
        tick(); tick();
        checks++; if (obs_a.size() != 160) $display("FAIL abort_restart_len got=%0d want=160", obs_a.size()); else passed++;
        for (int i = 0; i < obs_a.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_a[i] !== exp_q[i]) $display("FAIL abort_restart[%0d] got=%h want=%h", i, obs_a[i], exp_q[i]); else passed++;
        end
    endtask

    task automatic test_single_reg();
        int s, n, dc0;
        logic [7:0] lit [4];
        lit = '{8'hA5, 8'hA5, 8'h00, 8'h01};
        randomize_regs();
        regs[31] = 32'hA5A5_0001;
        build_exp(31, 31, 0);
        obs_b.delete();
        dc0 = done_cnt_b;
        ready_b = 1'b1;
        s = cyc;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (done_cnt_b == dc0 && n < 100) begin tick(); n++; end
        repeat (15) tick();
        checks++; if (done_cnt_b - dc0 != 1) $display("FAIL single_done_count got=%0d want=1", done_cnt_b - dc0); else passed++;
        checks++; if (done_cyc_b - s != 6) $display("FAIL single_done_cycle got=%0d want=6", done_cyc_b - s); else passed++;
        checks++; if (obs_b.size() != 4) $display("FAIL single_len got=%0d want=4", obs_b.size()); else passed++;
        for (int i = 0; i < 4 && i < obs_b.size(); i++) begin
            checks++; if (obs_b[i] !== lit[i] || obs_b[i] !== exp_q[i]) $display("FAIL single_byte[%0d] got=%h want=%h", i, obs_b[i], exp_q[i]); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        randomize_regs();
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (30) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++; if (valid_a !== 1'b0) $display("FAIL rstmid_valid got=%b want=0", valid_a); else passed++;
        checks++; if (byte_a !== 8'h00) $display("FAIL rstmid_data got=%h want=00", byte_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", busy_a); else passed++;
        checks++; if (done_a !== 1'b0) $display("FAIL rstmid_done got=%b want=0", done_a); else passed++;
        checks++; if (addr_a !== 5'd0) $display("FAIL rstmid_addr got=%0d want=0", addr_a); else passed++;
        n0 = obs_a.size();
        for (int i = 0; i < 10; i++) begin ready_a = i[0]; tick(); end
        checks++; if (obs_a.size() != n0) $display("FAIL rstmid_no_bytes got=%0d want=0 new", obs_a.size() - n0); else passed++;
    endtask

    initial begin
        reset_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_snapshot();
        test_abort();
        test_single_reg();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
